sr_shift_sequencer: RTL and testbench
=====================================

// Module: sr_shift_sequencer
// PURPOSE
//  Wishbone-programmed sequencer for the user-area serial shift-register chain.
//  Firmware loads a TX word, length, bit order and serial-clock divider, then starts a transfer.
//  The block shifts TX out on sr_sdo, captures sr_sdi into RX, and pulses sr_latch at the end.
//  Sits in user_project_wrapper between the WB slave port and the SR datapath.
// PARAMETERS
//  BASE_ADDRESS  32'h3000_0000  WB base; 4 word registers at +0x0..+0xC
//  WIDTH         32             max chain length / TX, RX register width (must be 32)
//  DIV_W         8              width of serial-clock divider field
// PORTS
//  wb_clk_i   in   1      system clock
//  wb_rst_i   in   1      reset; asynchronous, active-high
//  wbs_cyc_i  in   1      WB cycle
//  wbs_stb_i  in   1      WB strobe
//  wbs_we_i   in   1      WB write enable
//  wbs_sel_i  in   4      WB byte selects
//  wbs_adr_i  in   32     WB address
//  wbs_dat_i  in   32     WB write data
//  wbs_ack_o  out  1      WB acknowledge
//  wbs_dat_o  out  32     WB read data
//  sr_clk     out  1      serial shift clock to chain
//  sr_sdo     out  1      serial data to chain
//  sr_sdi     in   1      serial data from chain
//  sr_latch   out  1      one-cycle update pulse after the last bit
//  irq        out  1      transfer-done interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; CTRL=0, TX=0, RX=0, STATUS=0; FSM=IDLE.
//  Decode: hit = cyc&stb & (adr[31:4]==BASE_ADDRESS[31:4]); reg = adr[3:2]. Miss: no ack.
//  WB: ack asserted the cycle after a hit while ack=0; 1-cycle pulse; reads 0-wait-state registered.
//  Byte selects honoured on every RW field; unused bits read 0.
//  0x0 CTRL  [0] START (write 1, self-clear, reads 0) [1] LSB_FIRST [2] IE
//            [12:8] LEN (bits = LEN+1, 1..32) [23:16] DIV
//  0x4 TX    RW; shifted copy internal, TX register itself unchanged by a transfer
//  0x8 RX    RO; captured bits, right-justified: bit k received lands in RX[k] for LSB_FIRST,
//            else RX shifts left, first bit ends in RX[LEN]; RX cleared at START
//  0xC STAT  [0] BUSY (RO) [1] DONE (sticky, W1C) [2] OVR (sticky, W1C)
//  FSM: IDLE -START-> LOAD(1 cyc: copy TX, clear RX, bitcnt=LEN, drive first sdo)
//   -> LOW(DIV+1 cyc, sr_clk=0) -> HIGH(DIV+1 cyc, sr_clk=1; sdi sampled on entry)
//   -> HIGH exit: bitcnt==0 ? LATCH : LOW with next sdo, bitcnt-1
//   -> LATCH(1 cyc, sr_latch=1, sr_clk=0) -> IDLE, DONE<=1.
//  Bit order: LSB_FIRST=1 sends TX[0] first; else sends TX[LEN] first.
//  Transfer length (cycles) = 2 + (LEN+1)*2*(DIV+1). BUSY=1 from LOAD through LATCH.
//  sr_sdo changes only at LOAD / LOW entry; stable through HIGH. sr_sdo=0 in IDLE.
//  Boundaries:
//   START while BUSY: ignored, OVR<=1. TX or CTRL write while BUSY: ignored, OVR<=1, still acked.
//   START with DONE=1: allowed; DONE stays until cleared.
//   W1C of DONE in same cycle as DONE set: set wins.
//   DIV=0: sr_clk toggles every cycle. LEN=0: single-bit transfer.
//   Reset mid-transfer: immediate return to IDLE, outputs 0, no sr_latch.
// CONFIGURATION
//  SR_SEQ_IRQ_EN defined: irq = DONE & IE (level, clears with DONE W1C).
//  Not defined: irq tied 0; CTRL[2] not stored, reads 0.
// TESTING
//  1 Reset mid-shift (LEN=7, DIV=3, assert wb_rst_i at bit 3) -> all outputs 0, BUSY=0, no sr_latch.
//  2 TX=0xA5, CTRL LEN=7 DIV=0 LSB_FIRST=1 START, sdi looped to sdo -> sdo seq 1,0,1,0,0,1,0,1;
//    RX=0xA5; sr_latch 1 cycle; total 18 cycles; DONE=1.
//  3 TX=0x8000_0001, LEN=31 DIV=2 MSB-first, sdi=1 -> first sdo=1, sr_clk period 6 cycles,
//    RX=0xFFFF_FFFF, BUSY for 194 cycles.
//  4 START again while BUSY; write TX=0x1234 while BUSY -> OVR=1, transfer unaffected, TX unchanged;
//    W1C 0x6 to STAT -> DONE=OVR=0.
//  5 LEN=0 DIV=0 TX=1 -> one sr_clk pulse, sdo=1, 4-cycle transfer; wbs_sel_i=4'b0010 write to
//    CTRL changes only LEN.
//  6 SR_SEQ_IRQ_EN on, IE=1 -> irq rises with DONE, falls after W1C; macro off -> irq=0, CTRL[2] reads 0.

Source files
------------

// File: rtl/sr_shift_sequencer.sv
// sr_shift_sequencer
//   Wishbone-programmed sequencer for the user-area serial shift-register chain.
//   Firmware loads TX, length, bit order and serial-clock divider through four word
//   registers, then sets START. The block shifts TX out on sr_sdo, captures sr_sdi
//   into RX and pulses sr_latch for one cycle after the last bit.
//
//   Register map (BASE_ADDRESS + offset):
//     0x0 CTRL  [0] START (W1, self-clear) [1] LSB_FIRST [2] IE [12:8] LEN [23:16] DIV
//     0x4 TX    RW
//     0x8 RX    RO
//     0xC STAT  [0] BUSY [1] DONE (W1C) [2] OVR (W1C)
//
//   Build option: define SR_SEQ_IRQ_EN to store CTRL.IE and drive irq = DONE & IE.
//   Without it irq is tied low and CTRL[2] reads 0.
//
//   Ports:
//     wb_clk_i, wb_rst_i        system clock, asynchronous active-high reset
//     wbs_*                     Wishbone slave (cyc, stb, we, sel, adr, dat in; ack, dat out)
//     sr_clk, sr_sdo, sr_latch  serial clock, serial data out, end-of-transfer update pulse
//     sr_sdi                    serial data returned from the chain
//     irq                       transfer-done interrupt (level)

module sr_shift_sequencer #(
   parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned DIV_W        = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        sr_clk,
   output logic        sr_sdo,
   input  logic        sr_sdi,
   output logic        sr_latch,
   output logic        irq
);

   localparam int unsigned LEN_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StLow,
      StHigh,
      StLatch
   } state_e;

   state_e state_q, state_d;

   // Configuration and data registers
   logic             lsb_first_q;
   logic [LEN_W-1:0] len_q;
   logic [DIV_W-1:0] div_q;
   logic [WIDTH-1:0] tx_q;
   logic [WIDTH-1:0] rx_q;
   logic             done_q;
   logic             ovr_q;
`ifdef SR_SEQ_IRQ_EN
   logic             ie_q;
`endif

   // Shift engine
   logic [WIDTH-1:0] sh_q;
   logic [LEN_W-1:0] bitcnt_q;
   logic [DIV_W-1:0] divcnt_q;
   logic             sdo_q;

   // Bus interface
   logic        ack_q;
   logic [31:0] dat_q;
   logic        hit;
   logic        access;
   logic        wr;
   logic        rd;
   logic [1:0]  addr_idx;
   logic        wr_ctrl;
   logic        wr_tx;
   logic        wr_stat;
   logic [31:0] rd_data;
   logic        unused_adr;

   // Control decode
   logic             busy;
   logic             start_req;
   logic             ovr_set;
   logic             done_set;
   logic             ctrl_upd;
   logic             lsb_first_nx;
   logic [LEN_W-1:0] len_nx;
   logic [LEN_W-1:0] len_m1;
   logic [LEN_W-1:0] rx_idx;
   logic             div_zero;
   logic             sclk;
   logic             latch;

   assign unused_adr = ^wbs_adr_i[1:0];

   // ---------------------------------------------------------------------------
   // Wishbone decode
   // ---------------------------------------------------------------------------
   assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDRESS[31:4]);
   assign access   = hit & ~ack_q;
   assign wr       = access & wbs_we_i;
   assign rd       = access & ~wbs_we_i;
   assign addr_idx = wbs_adr_i[3:2];
   assign wr_ctrl  = wr & (addr_idx == 2'd0);
   assign wr_tx    = wr & (addr_idx == 2'd1);
   assign wr_stat  = wr & (addr_idx == 2'd3);

   assign busy      = (state_q != StIdle);
   assign ctrl_upd  = wr_ctrl & ~busy;
   assign start_req = ctrl_upd & wbs_sel_i[0] & wbs_dat_i[0];
   // A write to CTRL or TX while shifting is dropped and flagged.
   assign ovr_set   = (wr_ctrl | wr_tx) & busy;
   assign done_set  = (state_q == StLatch);

   // START sees the fields written in the same access, not the stale ones.
   assign lsb_first_nx = (ctrl_upd & wbs_sel_i[0]) ? wbs_dat_i[1] : lsb_first_q;
   assign len_nx       = (ctrl_upd & wbs_sel_i[1]) ? wbs_dat_i[8 +: LEN_W] : len_q;

   assign len_m1   = len_q - LEN_W'(1);
   assign rx_idx   = len_q - bitcnt_q;
   assign div_zero = (divcnt_q == '0);

   always_comb begin
      rd_data = '0;
      case (addr_idx)
         2'd0: begin
            rd_data[1]             = lsb_first_q;
`ifdef SR_SEQ_IRQ_EN
            rd_data[2]             = ie_q;
`endif
            rd_data[8 +: LEN_W]    = len_q;
            rd_data[16 +: DIV_W]   = div_q;
         end
         2'd1: rd_data = tx_q;
         2'd2: rd_data = rx_q;
         default: rd_data[2:0] = {ovr_q, done_q, busy};
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= hit & ~ack_q;
         if (rd) begin
            dat_q <= rd_data;
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

   // ---------------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         lsb_first_q <= 1'b0;
         len_q       <= '0;
         div_q       <= '0;
         tx_q        <= '0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
`ifdef SR_SEQ_IRQ_EN
         ie_q        <= 1'b0;
`endif
      end else begin
         if (ctrl_upd) begin
            if (wbs_sel_i[0]) begin
               lsb_first_q <= wbs_dat_i[1];
`ifdef SR_SEQ_IRQ_EN
               ie_q        <= wbs_dat_i[2];
`endif
            end
            if (wbs_sel_i[1]) begin
               len_q <= wbs_dat_i[8 +: LEN_W];
            end
            if (wbs_sel_i[2]) begin
               div_q <= wbs_dat_i[16 +: DIV_W];
            end
         end

         if (wr_tx && !busy) begin
            for (int b = 0; b < 4; b++) begin
               if (wbs_sel_i[b]) begin
                  tx_q[8*b +: 8] <= wbs_dat_i[8*b +: 8];
               end
            end
         end

         // Set beats a simultaneous W1C.
         if (done_set) begin
            done_q <= 1'b1;
         end else if (wr_stat && wbs_sel_i[0] && wbs_dat_i[1]) begin
            done_q <= 1'b0;
         end

         if (ovr_set) begin
            ovr_q <= 1'b1;
         end else if (wr_stat && wbs_sel_i[0] && wbs_dat_i[2]) begin
            ovr_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sclk    = 1'b0;
      latch   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_req) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            state_d = StLow;
         end
         StLow: begin
            if (div_zero) begin
               state_d = StHigh;
            end
         end
         StHigh: begin
            sclk = 1'b1;
            if (div_zero) begin
               state_d = (bitcnt_q == '0) ? StLatch : StLow;
            end
         end
         StLatch: begin
            latch   = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign sr_clk   = sclk;
   assign sr_latch = latch;
   assign sr_sdo   = sdo_q;

   // ---------------------------------------------------------------------------
   // Shift datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sh_q     <= '0;
         rx_q     <= '0;
         bitcnt_q <= '0;
         divcnt_q <= '0;
         sdo_q    <= 1'b0;
      end else begin
         // Each LOW/HIGH phase lasts DIV+1 cycles: reload on entry, count down to zero.
         if ((state_q == StLoad) ||
             (((state_q == StLow) || (state_q == StHigh)) && div_zero)) begin
            divcnt_q <= div_q;
         end else if (!div_zero) begin
            divcnt_q <= divcnt_q - DIV_W'(1);
         end

         case (state_q)
            StIdle: begin
               if (start_req) begin
                  // Working copy taken on the way into LOAD so the first bit is on
                  // sr_sdo for the whole LOAD cycle.
                  sh_q     <= tx_q;
                  rx_q     <= '0;
                  bitcnt_q <= len_nx;
                  sdo_q    <= lsb_first_nx ? tx_q[0] : tx_q[len_nx];
               end
            end
            StLow: begin
               // sr_sdi is sampled on the rising edge of sr_clk.
               if (div_zero) begin
                  if (lsb_first_q) begin
                     rx_q[rx_idx] <= sr_sdi;
                  end else begin
                     rx_q <= {rx_q[WIDTH-2:0], sr_sdi};
                  end
               end
            end
            StHigh: begin
               if (div_zero && (bitcnt_q != '0)) begin
                  bitcnt_q <= bitcnt_q - LEN_W'(1);
                  if (lsb_first_q) begin
                     sdo_q <= sh_q[1];
                     sh_q  <= sh_q >> 1;
                  end else begin
                     sdo_q <= sh_q[len_m1];
                     sh_q  <= sh_q << 1;
                  end
               end
            end
            StLatch: begin
               sdo_q <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Interrupt
   // ---------------------------------------------------------------------------
`ifdef SR_SEQ_IRQ_EN
   assign irq = done_q & ie_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_sr_shift_sequencer.sv
// Self-checking bench for sr_shift_sequencer: register-access vector table, then
// hand-written transfers with an expected-bit scoreboard checked on each sr_clk rise.

module tb_sr_shift_sequencer;

   localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef SR_SEQ_IRQ_EN
   localparam logic [31:0] IE_RD   = 32'h4;
   localparam logic [31:0] IRQ_EXP = 32'h1;
`else
   localparam logic [31:0] IE_RD   = 32'h0;
   localparam logic [31:0] IRQ_EXP = 32'h0;
`endif

   logic        clk;
   logic        rst;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] wdat;
   logic        ack;
   logic [31:0] rdat;
   logic        sr_clk;
   logic        sr_sdo;
   logic        sr_sdi;
   logic        sr_latch;
   logic        irq;
   logic        sdi_loop;
   logic        sdi_val;

   int total;
   int bad;
   int cyc_n;
   int latch_cnt;
   int rise_cnt;
   int last_rise;
   int period;
   logic sclk_prev;

   logic [31:0] exp_sdo[$];
   logic [31:0] exp_rd[$];

   typedef struct {
      logic        we;
      logic [3:0]  off;
      logic [3:0]  sel;
      logic [31:0] wdat;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[19];

   sr_shift_sequencer dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .sr_clk    (sr_clk),
      .sr_sdo    (sr_sdo),
      .sr_sdi    (sr_sdi),
      .sr_latch  (sr_latch),
      .irq       (irq)
   );

   assign sr_sdi = sdi_loop ? sr_sdo : sdi_val;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Single clock step; also observes sr_clk rises and sr_latch pulses.
   task automatic tick();
      logic [31:0] e;
      @(posedge clk);
      #1;
      cyc_n++;
      if (sr_latch) latch_cnt++;
      if (sr_clk && !sclk_prev) begin
         rise_cnt++;
         period    = cyc_n - last_rise;
         last_rise = cyc_n;
         if (exp_sdo.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sdo_unexpected_rise: got rise at cycle %0d expected none", cyc_n);
         end else begin
            e = exp_sdo.pop_front();
            check("sdo_bit", {31'b0, sr_sdo}, e);
         end
      end
      sclk_prev = sr_clk;
   endtask

   task automatic wb_access(input logic [31:0] a, input logic w, input logic [3:0] s,
                            input logic [31:0] d, output logic [31:0] r, output logic ok);
      cyc  = 1'b1;
      stb  = 1'b1;
      we   = w;
      sel  = s;
      adr  = a;
      wdat = d;
      ok   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ack) begin
            ok = 1'b1;
            break;
         end
      end
      r   = rdat;
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
   endtask

   task automatic wr_reg(input string name, input logic [3:0] off, input logic [3:0] s,
                         input logic [31:0] d);
      logic [31:0] r;
      logic ok;
      wb_access(BASE + {28'b0, off}, 1'b1, s, d, r, ok);
      check({name, "_ack"}, {31'b0, ok}, 32'h1);
   endtask

   task automatic rd_check(input string name, input logic [3:0] off, input logic [31:0] exp);
      logic [31:0] r;
      logic [31:0] e;
      logic ok;
      exp_rd.push_back(exp);
      wb_access(BASE + {28'b0, off}, 1'b0, 4'hF, 32'h0, r, ok);
      e = exp_rd.pop_front();
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s: got no ack expected ack with %h", name, e);
      end else begin
         check(name, r, e);
      end
   endtask

   // Waits for sr_latch; n counts cycles from LOAD (n=1) to the LATCH cycle.
   task automatic wait_latch(input string name, output int n);
      n = 1;
      for (int i = 0; i < 1000; i++) begin
         tick();
         n++;
         if (sr_latch) return;
      end
      total++;
      bad++;
      $display("FAIL %s: got no sr_latch within 1000 cycles expected one", name);
   endtask

   task automatic push_bits(input logic [31:0] tx, input int len, input logic lsb);
      for (int i = 0; i <= len; i++) begin
         exp_sdo.push_back({31'b0, lsb ? tx[i] : tx[len - i]});
      end
   endtask

   initial begin
      int n;
      int latch0;
      int rise0;
      logic [31:0] r;
      logic ok;

      total = 0; bad = 0; cyc_n = 0; latch_cnt = 0; rise_cnt = 0; last_rise = 0;
      period = 0; sclk_prev = 1'b0;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
      sdi_loop = 1'b1; sdi_val = 1'b0;

      vecs[0]  = '{1'b0, 4'h0, 4'hF, 32'h0,         32'h0};
      vecs[1]  = '{1'b0, 4'h4, 4'hF, 32'h0,         32'h0};
      vecs[2]  = '{1'b0, 4'h8, 4'hF, 32'h0,         32'h0};
      vecs[3]  = '{1'b0, 4'hC, 4'hF, 32'h0,         32'h0};
      vecs[4]  = '{1'b1, 4'h4, 4'hF, 32'hDEAD_BEEF, 32'h0};
      vecs[5]  = '{1'b0, 4'h4, 4'hF, 32'h0,         32'hDEAD_BEEF};
      vecs[6]  = '{1'b1, 4'h4, 4'h5, 32'h1122_3344, 32'h0};
      vecs[7]  = '{1'b0, 4'h4, 4'hF, 32'h0,         32'hDE22_BE44};
      vecs[8]  = '{1'b1, 4'h0, 4'h2, 32'hFFFF_FFFF, 32'h0};
      vecs[9]  = '{1'b0, 4'h0, 4'hF, 32'h0,         32'h0000_1F00};
      vecs[10] = '{1'b0, 4'hC, 4'hF, 32'h0,         32'h0};
      vecs[11] = '{1'b1, 4'h0, 4'h5, 32'h00AB_0006, 32'h0};
      vecs[12] = '{1'b0, 4'h0, 4'hF, 32'h0,         32'h00AB_1F02 | IE_RD};
      vecs[13] = '{1'b1, 4'h8, 4'hF, 32'hFFFF_FFFF, 32'h0};
      vecs[14] = '{1'b0, 4'h8, 4'hF, 32'h0,         32'h0};
      vecs[15] = '{1'b1, 4'h0, 4'hF, 32'h0,         32'h0};
      vecs[16] = '{1'b0, 4'h0, 4'hF, 32'h0,         32'h0};
      vecs[17] = '{1'b1, 4'hC, 4'hF, 32'hFFFF_FFFF, 32'h0};
      vecs[18] = '{1'b0, 4'hC, 4'hF, 32'h0,         32'h0};

      repeat (3) tick();
      check("reset_outputs", {ack, sr_clk, sr_sdo, sr_latch, irq, 27'b0} | rdat, 32'h0);
      rst = 1'b0;

      // Register access table
      for (int i = 0; i < 19; i++) begin
         if (vecs[i].we) begin
            wr_reg($sformatf("vec%0d_wr", i), vecs[i].off, vecs[i].sel, vecs[i].wdat);
         end else begin
            rd_check($sformatf("vec%0d_rd", i), vecs[i].off, vecs[i].exp);
         end
      end

      // Address outside the block must not be acknowledged
      wb_access(BASE + 32'h10, 1'b0, 4'hF, 32'h0, r, ok);
      check("miss_no_ack", {31'b0, ok}, 32'h0);

      // LSB-first loopback, DIV=0
      sdi_loop = 1'b1;
      wr_reg("t2_tx", 4'h4, 4'hF, 32'hA5);
      push_bits(32'hA5, 7, 1'b1);
      latch0 = latch_cnt;
      wr_reg("t2_ctrl", 4'h0, 4'hF, 32'h0000_0703);
      wait_latch("t2_latch", n);
      check("t2_cycles", n, 18);
      tick();
      check("t2_latch_pulses", latch_cnt - latch0, 1);
      check("t2_bits_left", exp_sdo.size(), 0);
      rd_check("t2_rx", 4'h8, 32'hA5);
      rd_check("t2_stat", 4'hC, 32'h2);

      // 32-bit MSB-first, DIV=2, sdi held high
      sdi_loop = 1'b0;
      sdi_val  = 1'b1;
      wr_reg("t3_tx", 4'h4, 4'hF, 32'h8000_0001);
      push_bits(32'h8000_0001, 31, 1'b0);
      latch0 = latch_cnt;
      wr_reg("t3_ctrl", 4'h0, 4'hF, 32'h0002_1F01);
      wait_latch("t3_latch", n);
      check("t3_cycles", n, 194);
      tick();
      check("t3_sclk_period", period, 6);
      check("t3_latch_pulses", latch_cnt - latch0, 1);
      check("t3_bits_left", exp_sdo.size(), 0);
      rd_check("t3_rx", 4'h8, 32'hFFFF_FFFF);
      rd_check("t3_stat", 4'hC, 32'h2);

      // Writes while busy are dropped and flag OVR
      sdi_loop = 1'b1;
      wr_reg("t4_tx", 4'h4, 4'hF, 32'h5A);
      push_bits(32'h5A, 7, 1'b1);
      wr_reg("t4_ctrl", 4'h0, 4'hF, 32'h0001_0703);
      rd_check("t4_stat_busy", 4'hC, 32'h3);
      wr_reg("t4_restart", 4'h0, 4'hF, 32'h0000_0001);
      wr_reg("t4_tx_busy", 4'h4, 4'hF, 32'h1234);
      wait_latch("t4_latch", n);
      tick();
      check("t4_bits_left", exp_sdo.size(), 0);
      rd_check("t4_stat_ovr", 4'hC, 32'h6);
      rd_check("t4_tx_kept", 4'h4, 32'h5A);
      rd_check("t4_rx", 4'h8, 32'h5A);
      rd_check("t4_ctrl_kept", 4'h0, 32'h0001_0702);
      wr_reg("t4_w1c", 4'hC, 4'hF, 32'h6);
      rd_check("t4_stat_clr", 4'hC, 32'h0);

      // Single-bit transfer
      wr_reg("t5_tx", 4'h4, 4'hF, 32'h1);
      push_bits(32'h1, 0, 1'b0);
      latch0 = latch_cnt;
      rise0  = rise_cnt;
      wr_reg("t5_ctrl", 4'h0, 4'hF, 32'h0000_0001);
      wait_latch("t5_latch", n);
      check("t5_cycles", n, 4);
      tick();
      check("t5_rises", rise_cnt - rise0, 1);
      check("t5_latch_pulses", latch_cnt - latch0, 1);
      rd_check("t5_rx", 4'h8, 32'h1);

      // Interrupt
      wr_reg("t6_clr", 4'hC, 4'hF, 32'h6);
      wr_reg("t6_tx", 4'h4, 4'hF, 32'h0);
      push_bits(32'h0, 0, 1'b0);
      wr_reg("t6_ctrl", 4'h0, 4'hF, 32'h0000_0005);
      check("t6_irq_busy", {31'b0, irq}, 32'h0);
      wait_latch("t6_latch", n);
      tick();
      check("t6_irq_done", {31'b0, irq}, IRQ_EXP);
      rd_check("t6_ctrl_ie", 4'h0, IE_RD);
      wr_reg("t6_w1c", 4'hC, 4'h1, 32'h2);
      check("t6_irq_clr", {31'b0, irq}, 32'h0);

      // Reset in the middle of a transfer
      wr_reg("t1_tx", 4'h4, 4'hF, 32'hA5);
      push_bits(32'hA5, 7, 1'b1);
      latch0 = latch_cnt;
      rise0  = rise_cnt;
      wr_reg("t1_ctrl", 4'h0, 4'hF, 32'h0003_0701);
      for (int i = 0; i < 300; i++) begin
         tick();
         if (rise_cnt - rise0 >= 3) break;
      end
      check("t1_reached_bit3", rise_cnt - rise0, 3);
      rst = 1'b1;
      #1;
      check("t1_rst_outputs", {ack, sr_clk, sr_sdo, sr_latch, irq, 27'b0}, 32'h0);
      tick();
      rst = 1'b0;
      exp_sdo.delete();
      rise0 = rise_cnt;
      repeat (80) tick();
      check("t1_no_latch", latch_cnt - latch0, 0);
      check("t1_no_rises", rise_cnt - rise0, 0);
      rd_check("t1_stat", 4'hC, 32'h0);
      rd_check("t1_tx", 4'h4, 32'h0);
      rd_check("t1_ctrl", 4'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
